labyrinth_pixel_source: RTL and testbench

LABYRINTH_PIXEL_SOURCE -- requirements
Module: labyrinth_pixel_source

---
 rtl/lab_pkg.sv | 36 +++
 rtl/lab_map_ram.sv | 25 ++
 rtl/labyrinth_pixel_source.sv | 166 ++++++++++++++++
 tb/tb_labyrinth_pixel_source.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the labyrinth pixel source: tile codes, colours,
// move directions and the control state encoding.
package lab_pkg;

  localparam logic [1:0] TILE_FLOOR     = 2'd0;
  localparam logic [1:0] TILE_WALL      = 2'd1;
  localparam logic [1:0] TILE_GOAL      = 2'd2;
  localparam logic [1:0] TILE_FLOOR_ALT = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Byte order is B,G,R from MSB down, so the player colour is red.
  localparam logic [23:0] COL_FLOOR  = 24'h000000;
  localparam logic [23:0] COL_WALL   = 24'hFFFFFF;
  localparam logic [23:0] COL_GOAL   = 24'h00FF00;
  localparam logic [23:0] COL_PLAYER = 24'h0000FF;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  function automatic logic [23:0] tile_colour(input logic [1:0] tile);
    case (tile)
      TILE_WALL: tile_colour = COL_WALL;
      TILE_GOAL: tile_colour = COL_GOAL;
      default:   tile_colour = COL_FLOOR;
    endcase
  endfunction

endpackage

// File: rtl/lab_map_ram.sv
// Maze tile store: one synchronous write port, two asynchronous read ports
// (display scan-out and move collision lookup).
module lab_map_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13
) (
  input  logic          iVGA_CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] disp_addr,
  output logic [1:0]    disp_tile,
  input  logic [AW-1:0] col_addr,
  output logic [1:0]    col_tile
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge iVGA_CLK)
    if (we) mem[waddr] <= wdata;

  assign disp_tile = mem[disp_addr];
  assign col_tile  = mem[col_addr];

endmodule

// File: rtl/labyrinth_pixel_source.sv
// Maze renderer with a move-at-vsync player. Define PLAYER_BLINK_EN to make
// the player cell blink on a 64-frame cycle.
module labyrinth_pixel_source
  import lab_pkg::*;
#(
  parameter int GRID_W  = 80,
  parameter int GRID_H  = 60,
  parameter int START_X = 1,
  parameter int START_Y = 1
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [8:0]  iRow,
  input  logic [9:0]  iColumn,
  input  logic        iVS,
  output logic [23:0] oBGR,
  input  logic        iWr_valid,
  input  logic [6:0]  iWr_x,
  input  logic [5:0]  iWr_y,
  input  logic [1:0]  iWr_tile,
  output logic        oWr_ready,
  input  logic        iMove_valid,
  input  logic [1:0]  iMove_dir,
  output logic        oMove_ready,
  output logic        oMove_blocked,
  output logic        oWin,
  input  logic        iClear_win,
  output logic        oInit_busy
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt;
  logic [6:0]    pos_x, tgt_x;
  logic [5:0]    pos_y, tgt_y;
  logic [1:0]    dir_q;
  logic          vs_q, vs_fall;
  logic          win_q, blocked_q;
  logic          at_edge, blocked, win_set;
  logic          ram_we, wr_in_grid, disp_in, player_here, show_player;
  logic [AW-1:0] ram_waddr, disp_addr, col_addr;
  logic [1:0]    ram_wdata, disp_tile, col_tile;
  logic [23:0]   bgr;

  assign vs_fall = vs_q & ~iVS;

  always_comb begin
    state_d     = state_q;
    oInit_busy  = 1'b0;
    oWr_ready   = 1'b0;
    oMove_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        oInit_busy = 1'b1;
        if (int'(init_cnt) == CELLS - 1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        oWr_ready   = 1'b1;
        oMove_ready = 1'b1;
        if (iMove_valid) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        oWr_ready = 1'b1;
        if (vs_fall) state_d = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Target stays on the current cell at a grid edge, so nothing ever wraps.
  always_comb begin
    at_edge = 1'b0;
    tgt_x   = pos_x;
    tgt_y   = pos_y;
    case (dir_q)
      DIR_UP:    if (pos_y == 6'd0) at_edge = 1'b1; else tgt_y = pos_y - 6'd1;
      DIR_RIGHT: if (int'(pos_x) == GRID_W - 1) at_edge = 1'b1; else tgt_x = pos_x + 7'd1;
      DIR_DOWN:  if (int'(pos_y) == GRID_H - 1) at_edge = 1'b1; else tgt_y = pos_y + 6'd1;
      default:   if (pos_x == 7'd0) at_edge = 1'b1; else tgt_x = pos_x - 7'd1;
    endcase
  end

  assign col_addr = AW'(int'(tgt_y) * GRID_W + int'(tgt_x));
  assign blocked  = at_edge | (col_tile == TILE_WALL);
  assign win_set  = (state_q == ST_CHECK) & ~blocked & (col_tile == TILE_GOAL);

  assign wr_in_grid = (int'(iWr_x) < GRID_W) && (int'(iWr_y) < GRID_H);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = init_cnt;
    ram_wdata = TILE_FLOOR;
    if (state_q == ST_INIT) begin
      ram_we = 1'b1;
    end else if (oWr_ready && iWr_valid && wr_in_grid) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(int'(iWr_y) * GRID_W + int'(iWr_x));
      ram_wdata = iWr_tile;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= ST_INIT;
      init_cnt  <= '0;
      pos_x     <= 7'(START_X);
      pos_y     <= 6'(START_Y);
      dir_q     <= DIR_UP;
      vs_q      <= 1'b1;
      win_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= iVS;
      blocked_q <= (state_q == ST_CHECK) & blocked;
      if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (oMove_ready && iMove_valid) dir_q <= iMove_dir;
      if (state_q == ST_CHECK && !blocked) begin
        pos_x <= tgt_x;
        pos_y <= tgt_y;
      end
      if (win_set)         win_q <= 1'b1;
      else if (iClear_win) win_q <= 1'b0;
    end
  end

  assign oMove_blocked = blocked_q;
  assign oWin          = win_q;

`ifdef PLAYER_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n)      frame_cnt <= '0;
    else if (vs_fall) frame_cnt <= frame_cnt + 6'd1;
  assign show_player = ~frame_cnt[5];
`else
  assign show_player = 1'b1;
`endif

  assign disp_in     = (int'(iRow) < GRID_H) && (int'(iColumn) < GRID_W);
  assign disp_addr   = disp_in ? AW'(int'(iRow) * GRID_W + int'(iColumn)) : '0;
  assign player_here = (int'(iRow) == int'(pos_y)) && (int'(iColumn) == int'(pos_x));

  always_comb begin
    bgr = COL_FLOOR;
    if (state_q != ST_INIT && disp_in) begin
      bgr = tile_colour(disp_tile);
      if (player_here && show_player) bgr = COL_PLAYER;
    end
  end
  assign oBGR = bgr;

  lab_map_ram #(.DEPTH(CELLS), .AW(AW)) u_map (
    .iVGA_CLK  (iVGA_CLK),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .disp_addr (disp_addr),
    .disp_tile (disp_tile),
    .col_addr  (col_addr),
    .col_tile  (col_tile)
  );

endmodule

// File: tb/tb_labyrinth_pixel_source.sv
// Directed bench: pixel table after map writes, then move/win/reset sequences.
module tb_labyrinth_pixel_source;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic [8:0]  iRow = '0;
  logic [9:0]  iColumn = '0;
  logic        iVS = 1'b1;
  logic [23:0] oBGR;
  logic        iWr_valid = 1'b0;
  logic [6:0]  iWr_x = '0;
  logic [5:0]  iWr_y = '0;
  logic [1:0]  iWr_tile = '0;
  logic        oWr_ready;
  logic        iMove_valid = 1'b0;
  logic [1:0]  iMove_dir = '0;
  logic        oMove_ready, oMove_blocked, oWin;
  logic        iClear_win = 1'b0;
  logic        oInit_busy;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 iVGA_CLK = ~iVGA_CLK;

  labyrinth_pixel_source dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iRow(iRow), .iColumn(iColumn),
    .iVS(iVS), .oBGR(oBGR), .iWr_valid(iWr_valid), .iWr_x(iWr_x),
    .iWr_y(iWr_y), .iWr_tile(iWr_tile), .oWr_ready(oWr_ready),
    .iMove_valid(iMove_valid), .iMove_dir(iMove_dir), .oMove_ready(oMove_ready),
    .oMove_blocked(oMove_blocked), .oWin(oWin), .iClear_win(iClear_win),
    .oInit_busy(oInit_busy)
  );

  typedef struct {
    string       name;
    int          row;
    int          col;
    logic [23:0] bgr;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic px(input string name, input int row, input int col, input logic [23:0] exp);
    @(negedge iVGA_CLK);
    iRow = 9'(row);
    iColumn = 10'(col);
    #1;
    chk(name, 32'(oBGR), 32'(exp));
  endtask

  task automatic wr(input int x, input int y, input logic [1:0] t);
    @(negedge iVGA_CLK);
    iWr_valid = 1'b1; iWr_x = 7'(x); iWr_y = 6'(y); iWr_tile = t;
    @(negedge iVGA_CLK);
    iWr_valid = 1'b0;
  endtask

  // Called at the negedge where reset is released; counts busy cycles.
  task automatic init_count(output int cnt);
    cnt = 0;
    while (oInit_busy && cnt < 10000) begin
      cnt++;
      @(negedge iVGA_CLK);
    end
  endtask

  // Issues a move, lingers in WAIT_VS, drops iVS; returns in the CHECK cycle.
  task automatic start_move(input logic [1:0] d);
    @(negedge iVGA_CLK);
    iMove_valid = 1'b1; iMove_dir = d;
    @(negedge iVGA_CLK);
    iMove_valid = 1'b0;
    chk("wait_move_ready", 32'(oMove_ready), 32'd0);
    chk("wait_wr_ready", 32'(oWr_ready), 32'd1);
    @(negedge iVGA_CLK);
    iVS = 1'b0;
    @(negedge iVGA_CLK);
    chk("check_wr_ready", 32'(oWr_ready), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"px_player",    1,  1, 24'h0000FF};
    vecs[1]  = '{"px_wall",      1,  2, 24'hFFFFFF};
    vecs[2]  = '{"px_goal",      2,  1, 24'h00FF00};
    vecs[3]  = '{"px_goal55",    5,  5, 24'h00FF00};
    vecs[4]  = '{"px_wall_last", 59, 79, 24'hFFFFFF};
    vecs[5]  = '{"px_floor3",    3,  3, 24'h000000};
    vecs[6]  = '{"px_col90",     10, 90, 24'h000000};
    vecs[7]  = '{"px_alias",     11, 10, 24'h000000};
    vecs[8]  = '{"px_row60",     60, 0, 24'h000000};
    vecs[9]  = '{"px_col80",     0,  80, 24'h000000};
    vecs[10] = '{"px_floor00",   0,  0, 24'h000000};

    #1 iRST_n = 1'b0;
    iRow = 9'd1; iColumn = 10'd1;
    #2;
    chk("rst_busy", 32'(oInit_busy), 32'd1);
    chk("rst_wr_ready", 32'(oWr_ready), 32'd0);
    chk("rst_move_ready", 32'(oMove_ready), 32'd0);
    chk("rst_bgr", 32'(oBGR), 32'd0);
    chk("rst_win", 32'(oWin), 32'd0);
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    init_count(n);
    chk("init_cycles", 32'(n), 32'd4800);
    chk("idle_wr_ready", 32'(oWr_ready), 32'd1);
    chk("idle_move_ready", 32'(oMove_ready), 32'd1);
    px("init_player", 1, 1, 24'h0000FF);

    wr(2, 1, 2'd1);
    wr(1, 2, 2'd2);
    wr(5, 5, 2'd2);
    wr(79, 59, 2'd1);
    wr(3, 3, 2'd3);
    wr(90, 10, 2'd1);
    for (int i = 0; i < 11; i++) px(vecs[i].name, vecs[i].row, vecs[i].col, vecs[i].bgr);

    // Right into the wall at (2,1).
    start_move(2'd1);
    @(negedge iVGA_CLK);
    iVS = 1'b1;
    chk("wall_blocked", 32'(oMove_blocked), 32'd1);
    chk("wall_win", 32'(oWin), 32'd0);
    @(negedge iVGA_CLK);
    chk("wall_blocked_end", 32'(oMove_blocked), 32'd0);
    px("wall_pos", 1, 1, 24'h0000FF);
    px("wall_kept", 1, 2, 24'hFFFFFF);

    // Down onto the goal at (1,2); win is sticky until cleared.
    start_move(2'd2);
    @(negedge iVGA_CLK);
    iVS = 1'b1;
    chk("goal_blocked", 32'(oMove_blocked), 32'd0);
    chk("goal_win", 32'(oWin), 32'd1);
    @(negedge iVGA_CLK);
    chk("goal_win_sticky", 32'(oWin), 32'd1);
    iClear_win = 1'b1;
    @(negedge iVGA_CLK);
    iClear_win = 1'b0;
    chk("win_cleared", 32'(oWin), 32'd0);
    px("goal_pos", 2, 1, 24'h0000FF);
    px("goal_old", 1, 1, 24'h000000);

    // Left onto a goal at (0,2) while clear is held: set wins, then clears.
    wr(0, 2, 2'd2);
    iClear_win = 1'b1;
    start_move(2'd3);
    @(negedge iVGA_CLK);
    iVS = 1'b1;
    chk("setclr_win", 32'(oWin), 32'd1);
    @(negedge iVGA_CLK);
    chk("setclr_after", 32'(oWin), 32'd0);
    iClear_win = 1'b0;
    px("left_pos", 2, 0, 24'h0000FF);
    px("left_goal_back", 2, 1, 24'h00FF00);

    // Left again from x=0 is off-grid.
    start_move(2'd3);
    @(negedge iVGA_CLK);
    iVS = 1'b1;
    chk("edge_blocked", 32'(oMove_blocked), 32'd1);
    @(negedge iVGA_CLK);
    chk("edge_blocked_end", 32'(oMove_blocked), 32'd0);
    px("edge_pos", 2, 0, 24'h0000FF);

    // Reset asserted mid-cycle while waiting for vsync.
    @(negedge iVGA_CLK);
    iMove_valid = 1'b1; iMove_dir = 2'd1;
    @(negedge iVGA_CLK);
    iMove_valid = 1'b0;
    iRow = 9'd2; iColumn = 10'd0;
    #2 iRST_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(oInit_busy), 32'd1);
    chk("mid_rst_wr_ready", 32'(oWr_ready), 32'd0);
    chk("mid_rst_move_ready", 32'(oMove_ready), 32'd0);
    chk("mid_rst_bgr", 32'(oBGR), 32'd0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    init_count(n);
    chk("reinit_cycles", 32'(n), 32'd4800);
    px("reinit_player", 1, 1, 24'h0000FF);
    px("reinit_old_pos", 2, 0, 24'h000000);
    px("reinit_wall_gone", 1, 2, 24'h000000);
    px("reinit_goal_gone", 2, 1, 24'h000000);

`ifdef PLAYER_BLINK_EN
    for (int i = 0; i < 64; i++) begin
      @(negedge iVGA_CLK);
      iVS = 1'b0;
      @(negedge iVGA_CLK);
      iVS = 1'b1;
      if (i == 31) px("blink_off", 1, 1, 24'h000000);
    end
    px("blink_on", 1, 1, 24'h0000FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
